// File: rtl/core_lsu.sv
// core_lsu: memory-stage load/store unit.
//   Accepts one memory op per handshake (req_*), issues a single aligned
//   32-bit bus access with byte enables (bus_*), and returns load data
//   shifted down and sign/zero-extended for writeback (resp_*).
//   Only one op is ever outstanding: req_ready is high only in IDLE.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   req_valid/req_ready        op handshake; req_dir, req_size, req_addr, req_wdata
//   resp_valid/resp_ready      result handshake; resp_rdata, resp_err
//   bus_req/bus_gnt            request handshake; bus_we, bus_addr, bus_be, bus_wdata
//   bus_rvalid, bus_rdata, bus_err   completion (reads and writes)
// Build option:
//   CORE_LSU_MISALIGN_EN  when defined, misaligned H/HU/W ops are issued at
//                         their natural alignment instead of faulting.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new op
// REQ   | bus_req high, bus fields held until bus_gnt
// WAIT  | granted, waiting for bus_rvalid
// RESP  | resp_valid high, result held until resp_ready
module core_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_dir,
  input  logic [2:0]      req_size,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            bus_req,
  input  logic            bus_gnt,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              dir_q, dir_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [XLEN-1:2]   waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              size_illegal;
  logic              misaligned;
  logic              fault;
  logic [1:0]        off_forced;
  logic [XLEN-1:0]   rshift;
  logic [XLEN-1:0]   load_ext;
  logic [3:0]        be;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      size_q  <= 3'b000;
      off_q   <= 2'b00;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      size_q  <= size_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request decode. The offset is always forced to the natural alignment of
  // the size; for an aligned op this is just addr[1:0], so the same path
  // serves both builds and only the fault decision differs.
  always_comb begin
    size_illegal = (req_size == 3'b011) || (req_size[2:1] == 2'b11);
    misaligned   = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_size[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_size[1:0])
      2'b01:   off_forced = {req_addr[1], 1'b0};
      2'b10:   off_forced = 2'b00;
      default: off_forced = req_addr[1:0];
    endcase
`ifdef CORE_LSU_MISALIGN_EN
    fault = size_illegal;
`else
    fault = size_illegal || misaligned;
`endif
  end

  // Load extraction from the captured lane offset.
  always_comb begin
    rshift = bus_rdata >> {off_q, 3'b000};
    case (size_q)
      3'b000:  load_ext = {{(XLEN-8){rshift[7]}}, rshift[7:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, rshift[7:0]};
      3'b001:  load_ext = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, rshift[15:0]};
      default: load_ext = rshift;
    endcase
  end

  always_comb begin
    case (size_q[1:0])
      2'b00:   be = 4'b0001 << off_q;
      2'b01:   be = 4'b0011 << off_q;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    size_d  = size_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          dir_d   = req_dir;
          size_d  = req_size;
          off_d   = off_forced;
          waddr_d = req_addr[XLEN-1:2];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = fault;
          state_d = fault ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          err_d   = bus_err;
          rdata_d = (dir_q || bus_err) ? '0 : load_ext;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are zero outside the state that owns them so stale op fields
  // never appear on the bus or the writeback port.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_err   = resp_valid ? err_q : 1'b0;
    bus_req    = (state_q == S_REQ);
    bus_we     = bus_req && dir_q;
    bus_addr   = bus_req ? {waddr_q, 2'b00} : '0;
    bus_be     = bus_req ? be : 4'b0000;
    bus_wdata  = bus_we ? (wdata_q << {off_q, 3'b000}) : '0;
  end

endmodule

// File: tb/tb_core_lsu.sv
module tb_core_lsu;

`ifdef CORE_LSU_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_dir;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        bus_req, bus_gnt, bus_we, bus_rvalid, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  core_lsu #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int nbytes(input logic [2:0] s);
    if (s[1:0] == 2'd0) return 1;
    if (s[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_fault(input logic [2:0] s, input logic [31:0] a);
    bit ill = (s == 3'd3) || (s == 3'd6) || (s == 3'd7);
    bit mis = ((a % 4) % nbytes(s)) != 0;
    return ill || (!MIS && mis);
  endfunction

  function automatic int m_off(input logic [2:0] s, input logic [31:0] a);
    int lo = int'(a % 4);
    return lo - (lo % nbytes(s));
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    int v = ((1 << nbytes(s)) - 1) << m_off(s, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] s, input logic [31:0] a,
                                          input logic [31:0] wd);
    longint v = longint'({32'd0, wd}) * (longint'(1) << (8 * m_off(s, a)));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_rdata(input bit dir, input logic [2:0] s,
                                          input logic [31:0] a, input logic [31:0] rd,
                                          input bit berr);
    longint v, span;
    if (dir || berr || m_fault(s, a)) return 32'd0;
    span = longint'(1) << (8 * nbytes(s));
    v = longint'({32'd0, rd}) / (longint'(1) << (8 * m_off(s, a)));
    v = v % span;
    if (!s[2] && nbytes(s) < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---------------- current op and per-cycle compare ----------------
  bit          busy = 1'b0;
  bit          cur_dir, cur_berr;
  logic [2:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata, cur_rd;

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
      if (!busy) chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
      if (bus_req === 1'b1) begin
        chk("bus_on_fault", {31'd0, busy && m_fault(cur_size, cur_addr)}, 32'd0);
        chk("bus_we",    {31'd0, bus_we}, {31'd0, cur_dir});
        chk("bus_addr",  bus_addr, {cur_addr[31:2], 2'b00});
        chk("bus_be",    {28'd0, bus_be}, {28'd0, m_be(cur_size, cur_addr)});
        chk("bus_wdata", bus_wdata, cur_dir ? m_wdata(cur_size, cur_addr, cur_wdata) : 32'd0);
      end
      if (busy && resp_valid === 1'b1) begin
        chk("resp_rdata", resp_rdata, m_rdata(cur_dir, cur_size, cur_addr, cur_rd, cur_berr));
        chk("resp_err", {31'd0, resp_err},
            {31'd0, m_fault(cur_size, cur_addr) || cur_berr});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic accept(input bit dir, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input bit berr,
                        output int acc);
    @(negedge clk);
    cur_dir = dir; cur_size = sz; cur_addr = addr; cur_wdata = wd;
    cur_rd = rd; cur_berr = berr;
    req_valid = 1'b1; req_dir = dir; req_size = sz; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    acc = cyc;
    #1;
    busy = 1'b1;
    req_valid = 1'b0; req_dir = ~dir; req_size = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hDEAD_BEEF;
  endtask

  task automatic run_op(input bit dir, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input bit berr,
                        input int gdly, input int rdly, input bit stray,
                        output logic [31:0] o_addr, output logic [3:0] o_be,
                        output logic [31:0] o_wd, output logic [31:0] o_rd,
                        output logic o_err, output int o_lat, output logic o_breq);
    int acc;
    int k;
    o_addr = '0; o_be = '0; o_wd = '0; o_breq = 1'b0;
    accept(dir, sz, addr, wd, rd, berr, acc);
    if (!m_fault(sz, addr)) begin
      @(negedge clk);
      repeat (gdly) begin
        if (stray) begin bus_rvalid = 1'b1; bus_rdata = 32'h5A5A_5A5A; bus_err = 1'b1; end
        @(negedge clk);
      end
      bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;
      o_breq = bus_req; o_addr = bus_addr; o_be = bus_be; o_wd = bus_wdata;
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd; bus_err = berr;
      @(posedge clk); #1;
      bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    end
    k = 0;
    @(negedge clk);
    while (resp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (resp_valid !== 1'b1) chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
    o_lat = cyc - acc;
    o_rd = resp_rdata; o_err = resp_err;
    repeat (rdly) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    busy = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_be"}, {28'd0, bus_be}, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
  endtask

  logic [31:0] a, w, r;
  logic [3:0]  be;
  logic        e, br;
  int          lat;
  int          acc0;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_dir = 1'b0; req_size = 3'b000;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rstn = 1'b1;

    // LB 0x1003
    run_op(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_0000, 1'b0, 0, 0, 1'b0, a, be, w, r, e, lat, br);
    chk("lb_addr", a, 32'h1000);
    chk("lb_be", {28'd0, be}, 32'b1000);
    chk("lb_rdata", r, 32'hFFFF_FF80);
    chk("lb_err", {31'd0, e}, 32'd0);
    chk("lb_latency", lat, 3);
    chk("lb_bus_req", {31'd0, br}, 32'd1);

    // LHU 0x2002
    run_op(1'b0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_1234, 1'b0, 0, 0, 1'b0, a, be, w, r, e, lat, br);
    chk("lhu_be", {28'd0, be}, 32'b1100);
    chk("lhu_rdata", r, 32'h0000_BEEF);

    // SB 0xAB at 0x3001
    run_op(1'b1, 3'b000, 32'h3001, 32'h0000_00AB, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0, a, be, w, r, e, lat, br);
    chk("sb_be", {28'd0, be}, 32'b0010);
    chk("sb_wdata", w, 32'h0000_AB00);
    chk("sb_rdata", r, 32'd0);

    // LH 0x5002, 4-cycle grant stall with stray rvalid in REQ, 3-cycle resp stall
    run_op(1'b0, 3'b001, 32'h5002, 32'h0, 32'h8001_0000, 1'b0, 4, 3, 1'b1, a, be, w, r, e, lat, br);
    chk("stall_addr", a, 32'h5000);
    chk("stall_rdata", r, 32'hFFFF_8001);
    chk("stall_latency", lat, 7);

    // LW 0x4002 misaligned
    run_op(1'b0, 3'b010, 32'h4002, 32'h0, 32'h1122_3344, 1'b0, 0, 0, 1'b0, a, be, w, r, e, lat, br);
    if (MIS) begin
      chk("lw_mis_addr", a, 32'h4000);
      chk("lw_mis_be", {28'd0, be}, 32'b1111);
      chk("lw_mis_rdata", r, 32'h1122_3344);
      chk("lw_mis_err", {31'd0, e}, 32'd0);
    end else begin
      chk("lw_mis_err", {31'd0, e}, 32'd1);
      chk("lw_mis_latency", lat, 1);
      chk("lw_mis_rdata", r, 32'd0);
    end

    // Illegal sizes
    run_op(1'b0, 3'b011, 32'h6000, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, a, be, w, r, e, lat, br);
    chk("ill011_err", {31'd0, e}, 32'd1);
    chk("ill011_latency", lat, 1);
    run_op(1'b1, 3'b110, 32'h6004, 32'h1234, 32'h0, 1'b0, 0, 0, 1'b0, a, be, w, r, e, lat, br);
    chk("ill110_err", {31'd0, e}, 32'd1);

    // Bus error on load
    run_op(1'b0, 3'b010, 32'h7000, 32'h0, 32'hCAFE_F00D, 1'b1, 1, 0, 1'b0, a, be, w, r, e, lat, br);
    chk("berr_err", {31'd0, e}, 32'd1);
    chk("berr_rdata", r, 32'd0);

    // SW and LBU
    run_op(1'b1, 3'b010, 32'h8000, 32'h1234_5678, 32'h0, 1'b0, 0, 0, 1'b0, a, be, w, r, e, lat, br);
    chk("sw_wdata", w, 32'h1234_5678);
    chk("sw_be", {28'd0, be}, 32'b1111);
    run_op(1'b0, 3'b100, 32'h9001, 32'h0, 32'h0000_F000, 1'b0, 0, 0, 1'b0, a, be, w, r, e, lat, br);
    chk("lbu_be", {28'd0, be}, 32'b0010);
    chk("lbu_rdata", r, 32'h0000_00F0);

    // Reset while in WAIT, then a stray completion
    accept(1'b0, 3'b010, 32'hA000, 32'h0, 32'h0, 1'b0, acc0);
    @(negedge clk);
    chk("rstw_bus_req", {31'd0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    busy = 1'b0;
    #1;
    chk_reset_vals("rstw");
    @(negedge clk);
    rstn = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    chk("stray_resp_valid", {31'd0, resp_valid}, 32'd0);

    // Recovery after reset
    run_op(1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_007F, 1'b0, 0, 0, 1'b0, a, be, w, r, e, lat, br);
    chk("post_rst_rdata", r, 32'h0000_007F);
    chk("post_rst_latency", lat, 3);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
